id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter WORD_LEN, default 16, instruction width.
REQ-002 Parameter REG_FILE_ADDR_LEN, default 4, register address width.
REQ-003 Parameter REG_FILE_SIZE, default 16, register data width.
REQ-004 Parameter EXE_CMD_LEN, default 4, ALU command width.
REQ-005 Ports SHALL be (name direction width meaning); one clock, reset synchronous active-high:
- clk in 1: rising-edge clock.
- rst in 1: synchronous active-high reset.
- hazard_detected in 1: insert bubble.
- flagZ in 1: zero flag from status register.
- instruction in WORD_LEN: instruction being decoded.
- reg1, reg2 in REG_FILE_SIZE: register-file read data for src1/src2.
- src1, src2 out REG_FILE_ADDR_LEN: combinational register-file read addresses.
- dest out REG_FILE_ADDR_LEN: write-back register.
- val1, val2 out REG_FILE_SIZE: operands.
- EXE_CMD out EXE_CMD_LEN: ALU command.
- branch_comm out 4: branch type.
- brTaken, MEM_R_EN, MEM_W_EN, WB_EN, is_imm_out, ST out 1: branch taken, load, store, register write, immediate operand, status-flag write.

Function
REQ-006 Fields: op=[15:12], rd=[11:8], rs1=[7:4], rs2=[3:0], imm8=[7:0], off12=[11:0].
REQ-007 src1=rs1 for all opcodes; src2=rd for STR, else rs2; both combinational, never registered.
REQ-008 Every other output SHALL be registered on rising clk; one-cycle latency from instruction to outputs.
REQ-009 EXE_CMD codes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 PASS2, 6 PASS1.
REQ-010 Decode table (op: EXE_CMD, WB_EN, ST, MEM_R_EN, MEM_W_EN, is_imm_out):
- 0000 ADD: 1,1,0,0,0,0; 0001 SUB: 2,1,0,0,0,0; 0010 AND: 3,1,0,0,0,0; 0011 OR: 4,1,0,0,0,0.
- 0101 CMP: 2,0,1,0,0,0; 0110 MOVI: 5,1,0,0,0,1; 0111 MOVR: 5,1,0,0,0,0.
- 1100 LDR: 6,1,0,1,0,0; 1101 STR: 6,0,0,0,1,0.
- 1000 BEQ, 1001 BNE, 1010 B: 0,0,0,0,0,1.
- 0100, 1011, 1110, 1111: NOP, all control 0.
REQ-011 val1=reg1; val2=zero-extended imm8 for MOVI, sign-extended off12 for branches, else reg2; MOVR moves rs2 (val2).
REQ-012 dest=rd for all opcodes (meaningful only when WB_EN=1).
REQ-013 branch_comm: BEQ 0001, BNE 0010, B 0100, else 0000.
REQ-014 brTaken = (BEQ & flagZ) | (BNE & ~flagZ) | B, flagZ sampled at the same edge as instruction.
REQ-015 hazard_detected=1 at an edge SHALL register a bubble: all control outputs, EXE_CMD, branch_comm, brTaken = 0; val/dest = 0.
REQ-016 hazard_detected SHALL NOT affect src1/src2.

Reset
REQ-017 rst=1 at a rising edge clears every registered output to 0; rst has priority over hazard_detected.
REQ-018 Reset mid-stream discards the instruction present at that edge; decode resumes on the first edge with rst=0.

Configuration
REQ-019 Macro ID_EXT_BRANCH_EN: defined -> BNE (1001) and B (1010) decode per REQ-010/013/014; undefined -> both decode as NOP, only BEQ branches.

Verification
REQ-020 instruction=0x0093 (ADD), reg1=5, reg2=7 -> src1=9, src2=3 immediately; next edge: EXE_CMD=1, WB_EN=1, dest=0, val1=5, val2=7.
REQ-021 instruction=0x5093 (CMP) -> EXE_CMD=2, ST=1, WB_EN=0.
REQ-022 instruction=0x6093 (MOVI) -> EXE_CMD=5, is_imm_out=1, val2=0x0093, dest=0.
REQ-023 instruction=0x8FFE (BEQ) with flagZ=0 -> brTaken=0; flagZ=1 -> brTaken=1, branch_comm=0001, val2=0xFFFE.
REQ-024 instruction=0xC093 (LDR) -> MEM_R_EN=1, WB_EN=1; 0xD093 (STR) -> MEM_W_EN=1, WB_EN=0, src2=0.
REQ-025 Any instruction with hazard_detected=1, then rst=1 -> all registered outputs 0 after each edge.

Source files
------------

// File: rtl/id_stage.sv
// Instruction decode stage: splits the instruction into register addresses, operands and ALU/memory/branch controls.
// Latency: src1/src2 are combinational; every other output is registered, one cycle after the instruction.
// Backpressure: none; hazard_detected replaces the decoded instruction with a bubble at the clock edge.
// Optional feature macro: ID_EXT_BRANCH_EN enables BNE (1001) and B (1010); without it only BEQ branches.
module id_stage #(
    parameter int WORD_LEN          = 16,
    parameter int REG_FILE_ADDR_LEN = 4,
    parameter int REG_FILE_SIZE     = 16,
    parameter int EXE_CMD_LEN       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hazard_detected,
    input  logic                         flagZ,
    input  logic [WORD_LEN-1:0]          instruction,
    input  logic [REG_FILE_SIZE-1:0]     reg1,
    input  logic [REG_FILE_SIZE-1:0]     reg2,
    output logic [REG_FILE_ADDR_LEN-1:0] src1,
    output logic [REG_FILE_ADDR_LEN-1:0] src2,
    output logic [REG_FILE_ADDR_LEN-1:0] dest,
    output logic [REG_FILE_SIZE-1:0]     val1,
    output logic [REG_FILE_SIZE-1:0]     val2,
    output logic [EXE_CMD_LEN-1:0]       EXE_CMD,
    output logic [3:0]                   branch_comm,
    output logic                         brTaken,
    output logic                         MEM_R_EN,
    output logic                         MEM_W_EN,
    output logic                         WB_EN,
    output logic                         is_imm_out,
    output logic                         ST
);

    // Opcodes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_CMP  = 4'b0101;
    localparam logic [3:0] OP_MOVI = 4'b0110;
    localparam logic [3:0] OP_MOVR = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;
    localparam logic [3:0] OP_B    = 4'b1010;
    localparam logic [3:0] OP_LDR  = 4'b1100;
    localparam logic [3:0] OP_STR  = 4'b1101;

    // ALU commands
    localparam logic [EXE_CMD_LEN-1:0] CMD_NOP   = EXE_CMD_LEN'(0);
    localparam logic [EXE_CMD_LEN-1:0] CMD_ADD   = EXE_CMD_LEN'(1);
    localparam logic [EXE_CMD_LEN-1:0] CMD_SUB   = EXE_CMD_LEN'(2);
    localparam logic [EXE_CMD_LEN-1:0] CMD_AND   = EXE_CMD_LEN'(3);
    localparam logic [EXE_CMD_LEN-1:0] CMD_OR    = EXE_CMD_LEN'(4);
    localparam logic [EXE_CMD_LEN-1:0] CMD_PASS2 = EXE_CMD_LEN'(5);
    localparam logic [EXE_CMD_LEN-1:0] CMD_PASS1 = EXE_CMD_LEN'(6);

`ifdef ID_EXT_BRANCH_EN
    localparam bit EXT_BRANCH = 1'b1;
`else
    localparam bit EXT_BRANCH = 1'b0;
`endif

    // Instruction fields
    logic [3:0]                   op;
    logic [REG_FILE_ADDR_LEN-1:0] rd;
    logic [REG_FILE_ADDR_LEN-1:0] rs1;
    logic [REG_FILE_ADDR_LEN-1:0] rs2;
    logic [7:0]                   imm8;
    logic [11:0]                  off12;

    assign op    = instruction[15:12];
    assign rd    = instruction[11:8];
    assign rs1   = instruction[7:4];
    assign rs2   = instruction[3:0];
    assign imm8  = instruction[7:0];
    assign off12 = instruction[11:0];

    // Register-file read addresses bypass the pipeline register; STR reads its data register through src2.
    assign src1 = rs1;
    assign src2 = (op == OP_STR) ? rd : rs2;

    // Next-state values of the decode register
    logic [EXE_CMD_LEN-1:0]       nxt_cmd;
    logic [3:0]                   nxt_bc;
    logic                         nxt_br;
    logic                         nxt_mr;
    logic                         nxt_mw;
    logic                         nxt_wb;
    logic                         nxt_imm;
    logic                         nxt_st;
    logic [REG_FILE_SIZE-1:0]     nxt_val2;

    // Decode the opcode into controls and select the second operand
    always_comb begin
        nxt_cmd  = CMD_NOP;
        nxt_bc   = 4'b0000;
        nxt_br   = 1'b0;
        nxt_mr   = 1'b0;
        nxt_mw   = 1'b0;
        nxt_wb   = 1'b0;
        nxt_imm  = 1'b0;
        nxt_st   = 1'b0;
        nxt_val2 = reg2;
        case (op)
            OP_ADD:  begin nxt_cmd = CMD_ADD; nxt_wb = 1'b1; end
            OP_SUB:  begin nxt_cmd = CMD_SUB; nxt_wb = 1'b1; end
            OP_AND:  begin nxt_cmd = CMD_AND; nxt_wb = 1'b1; end
            OP_OR:   begin nxt_cmd = CMD_OR;  nxt_wb = 1'b1; end
            OP_CMP:  begin nxt_cmd = CMD_SUB; nxt_st = 1'b1; end
            OP_MOVI: begin
                nxt_cmd  = CMD_PASS2;
                nxt_wb   = 1'b1;
                nxt_imm  = 1'b1;
                nxt_val2 = {{(REG_FILE_SIZE-8){1'b0}}, imm8};
            end
            OP_MOVR: begin nxt_cmd = CMD_PASS2; nxt_wb = 1'b1; end
            OP_LDR:  begin nxt_cmd = CMD_PASS1; nxt_wb = 1'b1; nxt_mr = 1'b1; end
            OP_STR:  begin nxt_cmd = CMD_PASS1; nxt_mw = 1'b1; end
            OP_BEQ:  begin
                nxt_imm  = 1'b1;
                nxt_bc   = 4'b0001;
                nxt_br   = flagZ;
                nxt_val2 = {{(REG_FILE_SIZE-12){off12[11]}}, off12};
            end
            OP_BNE:  begin
                if (EXT_BRANCH) begin
                    nxt_imm  = 1'b1;
                    nxt_bc   = 4'b0010;
                    nxt_br   = ~flagZ;
                    nxt_val2 = {{(REG_FILE_SIZE-12){off12[11]}}, off12};
                end
            end
            OP_B:    begin
                if (EXT_BRANCH) begin
                    nxt_imm  = 1'b1;
                    nxt_bc   = 4'b0100;
                    nxt_br   = 1'b1;
                    nxt_val2 = {{(REG_FILE_SIZE-12){off12[11]}}, off12};
                end
            end
            default: ;
        endcase
    end

    // Pipeline register: reset and bubble both clear every field, reset taking priority
    always_ff @(posedge clk) begin
        if (rst || hazard_detected) begin
            dest        <= '0;
            val1        <= '0;
            val2        <= '0;
            EXE_CMD     <= '0;
            branch_comm <= '0;
            brTaken     <= 1'b0;
            MEM_R_EN    <= 1'b0;
            MEM_W_EN    <= 1'b0;
            WB_EN       <= 1'b0;
            is_imm_out  <= 1'b0;
            ST          <= 1'b0;
        end else begin
            dest        <= rd;
            val1        <= reg1;
            val2        <= nxt_val2;
            EXE_CMD     <= nxt_cmd;
            branch_comm <= nxt_bc;
            brTaken     <= nxt_br;
            MEM_R_EN    <= nxt_mr;
            MEM_W_EN    <= nxt_mw;
            WB_EN       <= nxt_wb;
            is_imm_out  <= nxt_imm;
            ST          <= nxt_st;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed examples followed by randomized instructions against a table-driven model.
// Latency: outputs compared one clock after inputs are applied; src1/src2 compared before the edge.
// Backpressure: hazard_detected and rst are randomized alongside the instruction stream.
module tb_id_stage;

`ifdef ID_EXT_BRANCH_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        hazard_detected;
    logic        flagZ;
    logic [15:0] instruction;
    logic [15:0] reg1;
    logic [15:0] reg2;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  dest;
    logic [15:0] val1;
    logic [15:0] val2;
    logic [3:0]  EXE_CMD;
    logic [3:0]  branch_comm;
    logic        brTaken;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        WB_EN;
    logic        is_imm_out;
    logic        ST;

    int total = 0;
    int bad   = 0;

    id_stage dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .flagZ           (flagZ),
        .instruction     (instruction),
        .reg1            (reg1),
        .reg2            (reg2),
        .src1            (src1),
        .src2            (src2),
        .dest            (dest),
        .val1            (val1),
        .val2            (val2),
        .EXE_CMD         (EXE_CMD),
        .branch_comm     (branch_comm),
        .brTaken         (brTaken),
        .MEM_R_EN        (MEM_R_EN),
        .MEM_W_EN        (MEM_W_EN),
        .WB_EN           (WB_EN),
        .is_imm_out      (is_imm_out),
        .ST              (ST)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [3:0]  bc;
        logic        br;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        imm;
        logic        st;
        logic [3:0]  dest;
        logic [15:0] v1;
        logic [15:0] v2;
    } exp_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Decode table row {cmd, wb, st, mr, mw, imm} for each opcode.
    function automatic logic [8:0] table_row(input logic [3:0] op);
        case (op)
            4'h0: return {4'd1, 5'b10000};
            4'h1: return {4'd2, 5'b10000};
            4'h2: return {4'd3, 5'b10000};
            4'h3: return {4'd4, 5'b10000};
            4'h5: return {4'd2, 5'b01000};
            4'h6: return {4'd5, 5'b10001};
            4'h7: return {4'd5, 5'b10000};
            4'h8: return {4'd0, 5'b00001};
            4'h9: return EXT ? {4'd0, 5'b00001} : 9'd0;
            4'hA: return EXT ? {4'd0, 5'b00001} : 9'd0;
            4'hC: return {4'd6, 5'b10100};
            4'hD: return {4'd6, 5'b00010};
            default: return 9'd0;
        endcase
    endfunction

    function automatic exp_t model(input logic [15:0] ins, input logic [15:0] r1, input logic [15:0] r2,
                                   input logic fz, input logic hz, input logic rs);
        exp_t e;
        logic [3:0] op;
        logic [8:0] row;
        int off;
        e = '0;
        if (rs || hz) return e;
        op  = ins[15:12];
        row = table_row(op);
        e.cmd = row[8:5];
        e.wb  = row[4];
        e.st  = row[3];
        e.mr  = row[2];
        e.mw  = row[1];
        e.imm = row[0];
        if (op == 4'h8)              e.bc = 4'b0001;
        else if (EXT && op == 4'h9)  e.bc = 4'b0010;
        else if (EXT && op == 4'hA)  e.bc = 4'b0100;
        e.br   = (e.bc == 4'b0001 && fz) || (e.bc == 4'b0010 && !fz) || (e.bc == 4'b0100);
        e.dest = ins[11:8];
        e.v1   = r1;
        off    = int'(ins[11:0]);
        if (off >= 2048) off = off - 4096;
        if (op == 4'h6)        e.v2 = 16'(int'(ins[7:0]));
        else if (e.bc != 4'b0) e.v2 = 16'(off);
        else                   e.v2 = r2;
        return e;
    endfunction

    // Apply one instruction, check read addresses before the edge and registered outputs after it.
    task automatic apply(input logic [15:0] ins, input logic [15:0] r1, input logic [15:0] r2,
                         input logic fz, input logic hz, input logic rs);
        exp_t e;
        instruction     = ins;
        reg1            = r1;
        reg2            = r2;
        flagZ           = fz;
        hazard_detected = hz;
        rst             = rs;
        #1;
        check_eq("src1", 32'(src1), 32'(ins[7:4]));
        check_eq("src2", 32'(src2), (ins[15:12] == 4'hD) ? 32'(ins[11:8]) : 32'(ins[3:0]));
        e = model(ins, r1, r2, fz, hz, rs);
        @(posedge clk);
        #1;
        check_eq("EXE_CMD",     32'(EXE_CMD),     32'(e.cmd));
        check_eq("branch_comm", 32'(branch_comm), 32'(e.bc));
        check_eq("brTaken",     32'(brTaken),     32'(e.br));
        check_eq("MEM_R_EN",    32'(MEM_R_EN),    32'(e.mr));
        check_eq("MEM_W_EN",    32'(MEM_W_EN),    32'(e.mw));
        check_eq("WB_EN",       32'(WB_EN),       32'(e.wb));
        check_eq("is_imm_out",  32'(is_imm_out),  32'(e.imm));
        check_eq("ST",          32'(ST),          32'(e.st));
        check_eq("dest",        32'(dest),        32'(e.dest));
        check_eq("val1",        32'(val1),        32'(e.v1));
        check_eq("val2",        32'(val2),        32'(e.v2));
    endtask

    initial begin
        rst = 1'b1; hazard_detected = 1'b0; flagZ = 1'b0;
        instruction = 16'h0; reg1 = 16'h0; reg2 = 16'h0;

        // Reset with a live instruction present: everything must read zero.
        apply(16'h0093, 16'd5, 16'd7, 1'b1, 1'b0, 1'b1);
        apply(16'h6093, 16'd5, 16'd7, 1'b1, 1'b1, 1'b1);

        // Worked examples with literal expectations.
        instruction = 16'h0093; #1;
        check_eq("ex_add_src1", 32'(src1), 32'd9);
        check_eq("ex_add_src2", 32'(src2), 32'd3);
        apply(16'h0093, 16'd5, 16'd7, 1'b0, 1'b0, 1'b0);
        check_eq("ex_add_cmd",  32'(EXE_CMD), 32'd1);
        check_eq("ex_add_wb",   32'(WB_EN),   32'd1);
        check_eq("ex_add_val2", 32'(val2),    32'd7);
        apply(16'h5093, 16'd5, 16'd7, 1'b0, 1'b0, 1'b0);
        check_eq("ex_cmp_st",   32'(ST),      32'd1);
        check_eq("ex_cmp_cmd",  32'(EXE_CMD), 32'd2);
        apply(16'h6093, 16'd5, 16'd7, 1'b0, 1'b0, 1'b0);
        check_eq("ex_movi_val2", 32'(val2),   32'h0093);
        check_eq("ex_movi_imm",  32'(is_imm_out), 32'd1);
        apply(16'h8FFE, 16'd5, 16'd7, 1'b0, 1'b0, 1'b0);
        check_eq("ex_beq_nt", 32'(brTaken), 32'd0);
        apply(16'h8FFE, 16'd5, 16'd7, 1'b1, 1'b0, 1'b0);
        check_eq("ex_beq_t",    32'(brTaken),     32'd1);
        check_eq("ex_beq_bc",   32'(branch_comm), 32'd1);
        check_eq("ex_beq_val2", 32'(val2),        32'hFFFE);
        apply(16'hC093, 16'd5, 16'd7, 1'b0, 1'b0, 1'b0);
        check_eq("ex_ldr_mr", 32'(MEM_R_EN), 32'd1);
        instruction = 16'hD093; #1;
        check_eq("ex_str_src2", 32'(src2), 32'd0);
        apply(16'hD093, 16'd5, 16'd7, 1'b0, 1'b0, 1'b0);
        check_eq("ex_str_mw", 32'(MEM_W_EN), 32'd1);
        check_eq("ex_str_wb", 32'(WB_EN),    32'd0);

        // Extended branches, both flag values; bubble then reset over a live instruction.
        apply(16'h9123, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0);
        apply(16'h9123, 16'd1, 16'd2, 1'b1, 1'b0, 1'b0);
        apply(16'hA801, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0);
        apply(16'h0093, 16'd5, 16'd7, 1'b0, 1'b1, 1'b0);
        check_eq("ex_bubble_val1", 32'(val1), 32'd0);
        apply(16'h0093, 16'd5, 16'd7, 1'b0, 1'b0, 1'b1);
        apply(16'h1234, 16'd9, 16'd8, 1'b0, 1'b0, 1'b0);

        // Randomized stream with occasional bubbles and resets.
        for (int i = 0; i < 600; i++) begin
            apply(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
